cfg_dprio_csr_shift_ctrl: RTL and testbench
===========================================

Name: cfg_dprio_csr_shift_ctrl

Overview:
Sequencer that loads a serial CSR chain of NUM_REGS x DATA_WIDTH bits from a parallel word interface, and captures the previous chain contents for readback. It sits between the config/DPRIO host logic and the chain's csr_in/csr_en/csr_out pins. It generates csr_en only while a bit is actually being shifted, and stalls on host backpressure or ATPG scan shift so that its bit count never desynchronises from the chain.

Parameters:
DATA_WIDTH, 16, bits per CSR word; must be >= 2.
NUM_REGS, 1, number of words in the chain; must be >= 1.
BCNT_W, $clog2(DATA_WIDTH), bit counter width (derived; do not override).
WCNT_W, $clog2(NUM_REGS+1), word counter width (derived; do not override).

Ports:
clk  in  1  clock; the same clock that drives the chain.
rst_n  in  1  asynchronous active-low reset.
start  in  1  1-cycle pulse; begins a load of NUM_REGS words; ignored while busy.
wr_data  in  DATA_WIDTH  next word to shift in.
wr_valid  in  1  wr_data valid.
wr_ready  out  1  word accepted when wr_valid & wr_ready.
rd_data  out  DATA_WIDTH  word shifted out of the chain.
rd_valid  out  1  rd_data valid; held until it is consumed.
rd_ready  in  1  readback consumer ready.
scan_shift_n  in  1  low = ATPG shift; the controller pauses.
csr_in_o  out  1  serial data to the chain's csr_in.
csr_en_o  out  1  shift enable to the chain's csr_en.
csr_out_i  in  1  serial data from the chain's csr_out.
busy  out  1  high from the cycle after start until done.
done  out  1  1-cycle pulse after the last readback word is consumed.

Behaviour:
- Reset values: wr_ready=0, rd_valid=0, rd_data=0, csr_en_o=0, csr_in_o=0, busy=0, done=0. All state is cleared asynchronously. If reset is asserted mid-load, the load is abandoned and the chain is left partially shifted; the host must restart.
- FSM states: IDLE, FETCH, SHIFT, DRAIN, FIN.
- IDLE -> FETCH on start. Set busy and clear wcnt.
- FETCH: wr_ready=1. On wr_valid, load shift register sreg<=wr_data, clear bcnt, -> SHIFT. No csr_en in FETCH.
- SHIFT: csr_in_o = sreg[DATA_WIDTH-1] (MSB first). csr_en_o = scan_shift_n.
  - When csr_en_o=1 at a posedge: sreg shifts left, capture register cap <= {cap[DATA_WIDTH-2:0], csr_out_i}, bcnt increments.
  - When scan_shift_n=0: csr_en_o=0 and there is no shift and no count change.
  - After bcnt reaches DATA_WIDTH-1 and that bit shifts, -> DRAIN.
- csr_out_i is sampled at the same posedge on which its bit leaves the chain. This holds whether or not the chain has its negative-edge output FF, because that FF captures the same value half a cycle earlier. No extra latency is required.
- DRAIN: rd_data<=cap and rd_valid=1 (registered). On rd_ready, rd_valid drops and wcnt increments. If wcnt == NUM_REGS-1, -> FIN; else -> FETCH. csr_en_o stays 0 while rd_valid is waiting.
- FIN: done=1 for one cycle, busy=0, -> IDLE.
- Chain ordering: the first word and bit shifted in ends farthest down the chain. The n-th readback word is the chain contents that were displaced by the n-th written word.
- Throughput: DATA_WIDTH+2 cycles per word with no stalls. The minimum total is NUM_REGS*(DATA_WIDTH+2)+1 cycles from start to done.
- wr_valid outside FETCH is ignored (wr_ready=0). rd_ready with rd_valid=0 has no effect.
- Simultaneous start and reset: reset wins.
- scan_shift_n low in a non-SHIFT state has no effect.
- Invariant: csr_en_o is never high outside SHIFT.

Decomposition:
- Shared package cfg_dprio_csr_pkg: the FSM state enum (IDLE, FETCH, SHIFT, DRAIN, FIN) and a localparam function for the counter widths.
- One sub-module: cfg_dprio_csr_shift_sreg. It holds the DATA_WIDTH parallel-load/serial-out register plus the serial-in capture register, with en and load inputs.
- The FSM and counters stay in the top-level module.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> all outputs 0; after release there is no activity until a fresh start.
- Single load, NUM_REGS=1, DATA_WIDTH=16, chain pre-filled 0xA5A5: start, write 0x1234 -> csr_in_o emits bits 0,0,0,1,0,0,1,0,... over 16 csr_en cycles; rd_data=0xA5A5; done at cycle 19; chain then holds 0x1234.
- NUM_REGS=3, writes 0x0001, 0x8000, 0xFFFF on an empty chain -> readback 0x0000 x3. A second load of 0,0,0 returns 0x0001, 0x8000, 0xFFFF in order.
- scan_shift_n pulsed low for 5 cycles mid-SHIFT -> csr_en_o=0 for those 5 cycles, bcnt frozen, final readback unchanged, done delayed by exactly 5 cycles.
- rd_ready held low for 10 cycles in DRAIN -> rd_valid/rd_data stable, csr_en_o=0 and wr_ready=0 throughout; the load resumes correctly afterwards.
- Run with a chain that has the negative-edge output FF and with one that does not -> identical readback; a start pulse while busy is ignored; reset at bit 7 of word 2 -> busy=0, done never pulses.

Source files
------------

// File: rtl/cfg_dprio_csr_pkg.sv
// Shared types for the DPRIO CSR chain shift controller.
// Holds the sequencer state encoding and the counter-width helper.
package cfg_dprio_csr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    DRAIN,
    FIN
  } csr_state_e;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_dprio_csr_shift_sreg.sv
// Parallel-load / serial-out shift register paired with a serial-in capture register.
// Both move together whenever en is high, so capture and launch stay bit-aligned.
module cfg_dprio_csr_shift_sreg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  en,
  input  logic                  ser_in,
  output logic                  ser_out,
  output logic [DATA_WIDTH-1:0] cap_nxt_o
);

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;

  always_comb begin
    sreg_d = sreg_q;
    cap_d  = cap_q;
    if (load) begin
      sreg_d = load_data;
    end else if (en) begin
      sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
      cap_d  = {cap_q[DATA_WIDTH-2:0], ser_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cap_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cap_q  <= cap_d;
    end
  end

  assign ser_out   = sreg_q[DATA_WIDTH-1];
  // Exposed so the last captured bit can reach rd_data on the same edge it arrives.
  assign cap_nxt_o = cap_d;

endmodule

// File: rtl/cfg_dprio_csr_shift_ctrl.sv
// Sequencer that writes NUM_REGS words into a serial CSR chain MSB first and
// returns the displaced chain contents word by word, stalling on scan shift or readback.
module cfg_dprio_csr_shift_ctrl
  import cfg_dprio_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 1,
  parameter int BCNT_W     = cnt_w(DATA_WIDTH),
  parameter int WCNT_W     = cnt_w(NUM_REGS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  scan_shift_n,
  output logic                  csr_in_o,
  output logic                  csr_en_o,
  input  logic                  csr_out_i,
  output logic                  busy,
  output logic                  done
);

  csr_state_e            state_q, state_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  sreg_load, shift_en, sreg_msb;
  logic [DATA_WIDTH-1:0] cap_nxt;

  // A chain bit only moves while shifting and the ATPG scan is not borrowing the chain.
  assign shift_en = (state_q == SHIFT) && scan_shift_n;

  cfg_dprio_csr_shift_sreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sreg_load),
    .load_data(wr_data),
    .en       (shift_en),
    .ser_in   (csr_out_i),
    .ser_out  (sreg_msb),
    .cap_nxt_o(cap_nxt)
  );

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    sreg_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          wcnt_d  = '0;
        end
      end
      FETCH: begin
        if (wr_valid) begin
          sreg_load = 1'b1;
          bcnt_d    = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
            state_d    = DRAIN;
            rd_valid_d = 1'b1;
            rd_data_d  = cap_nxt;
          end
        end
      end
      DRAIN: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          wcnt_d     = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_W'(NUM_REGS - 1)) begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign wr_ready = (state_q == FETCH);
  assign csr_en_o = shift_en;
  assign csr_in_o = (state_q == SHIFT) && sreg_msb;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cfg_dprio_csr_shift_ctrl.sv
// Directed bench: a bit-level chain model drives csr_out_i, a word-level scoreboard
// predicts what must be written, read back and when done must pulse.
module tb_cfg_dprio_csr_shift_ctrl;

  localparam int DW  = 16;
  localparam int NR  = 3;
  localparam int TOT = DW * NR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic          scan_shift_n = 1'b1;
  logic          csr_in_o, csr_en_o, csr_out_i;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_dprio_csr_shift_ctrl #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .scan_shift_n(scan_shift_n),
    .csr_in_o    (csr_in_o),
    .csr_en_o    (csr_en_o),
    .csr_out_i   (csr_out_i),
    .busy        (busy),
    .done        (done)
  );

  // External chain: chain[TOT-1] is the far end; optional negedge output FF.
  logic [TOT-1:0] chain = 48'hA5A5_5A5A_C3C3;
  logic           neg_q = 1'b0;
  logic           negff = 1'b0;
  always @(posedge clk) if (csr_en_o) chain <= {chain[TOT-2:0], csr_in_o};
  always @(negedge clk) neg_q <= chain[TOT-1];
  assign csr_out_i = negff ? neg_q : chain[TOT-1];

  // Word-level chain view; index 0 is the word at the far end.
  logic [DW-1:0] mchain [NR] = '{16'hA5A5, 16'h5A5A, 16'hC3C3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [DW-1:0] exp_wr_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic          bits_seen[$];
  logic [DW-1:0] rd_seen[$];
  logic [DW-1:0] cur_w = '0;
  int            bitpos = 0;
  int            rd_cnt = 0;
  bit            done_due = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", {wr_ready, rd_valid, csr_en_o, csr_in_o, busy, done, rd_data}, 64'd0);
      exp_wr_q.delete();
      exp_rd_q.delete();
      bitpos = 0;
      rd_cnt = 0;
      done_due = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("done", done, done_due);
      done_due = 1'b0;
      if (prev_hold) begin
        chk("rd_hold_valid", rd_valid, 1);
        chk("rd_hold_data", rd_data, prev_data);
      end
      if (wr_valid && wr_ready) begin
        if (exp_wr_q.size() == 0) chk("unexpected_fetch", 1, 0);
        else begin
          cur_w  = exp_wr_q.pop_front();
          bitpos = 0;
        end
      end
      if (csr_en_o) begin
        chk("en_vs_scan", scan_shift_n, 1);
        chk("en_vs_busy", busy, 1);
        if (bitpos < DW) chk("csr_in_bit", csr_in_o, cur_w[DW-1-bitpos]);
        else chk("extra_bit", bitpos, DW - 1);
        bits_seen.push_back(csr_in_o);
        bitpos++;
      end
      if (rd_valid) chk("drain_quiet", {csr_en_o, wr_ready}, 0);
      if (rd_valid && rd_ready) begin
        chk("bits_per_word", bitpos, DW);
        if (exp_rd_q.size() == 0) chk("unexpected_rd", 1, 0);
        else chk("rd_data", rd_data, exp_rd_q.pop_front());
        rd_seen.push_back(rd_data);
        rd_cnt++;
        if (rd_cnt == NR) begin
          rd_cnt = 0;
          done_due = 1'b1;
        end
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
    end
  end

  // One load: windows are in cycles counted from the start cycle (cycle 0).
  task automatic run_load(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                          input int scan_at, input int scan_len, input int rd_at, input int rd_len,
                          input int restart_at, input int abort_bit, output int lat);
    logic [DW-1:0] w [NR];
    int cyc, widx, en_cnt;
    bit hs;
    w = '{w0, w1, w2};
    bits_seen.delete();
    rd_seen.delete();
    for (int i = 0; i < NR; i++) begin
      exp_wr_q.push_back(w[i]);
      exp_rd_q.push_back(mchain[i]);
      mchain[i] = w[i];
    end
    lat = -1; cyc = 0; widx = 0; en_cnt = 0;
    start = 1'b1; wr_valid = 1'b1; wr_data = w[0];
    scan_shift_n = 1'b1; rd_ready = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      if (done) begin
        lat = cyc;
        break;
      end
      hs = wr_valid && wr_ready;
      if (csr_en_o && widx == 2) en_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) widx++;
      start        = (cyc == restart_at);
      wr_valid     = (widx < NR);
      wr_data      = w[(widx < NR) ? widx : 0];
      scan_shift_n = !(cyc >= scan_at && cyc < scan_at + scan_len);
      rd_ready     = !(cyc >= rd_at && cyc < rd_at + rd_len);
      if (abort_bit >= 0 && en_cnt == abort_bit) begin
        rst_n = 1'b0;
        break;
      end
    end
    start = 1'b0; wr_valid = 1'b0; scan_shift_n = 1'b1; rd_ready = 1'b1;
    if (lat < 0 && abort_bit < 0) chk("load_timeout", cyc, 0);
  endtask

  initial begin
    int lat;
    logic [7:0] exp8;
    logic [DW-1:0] lit [NR];

    // Reset held with start asserted: reset wins.
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {wr_ready, rd_valid, csr_en_o, csr_in_o, busy, done, rd_data}, 64'd0);
    rst_n = 1'b1; start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_after_reset", {busy, wr_ready, done, csr_en_o}, 0);
    end
    @(posedge clk); #1;

    // Load 1: pre-filled chain, posedge-only chain output.
    negff = 1'b0;
    run_load(16'h1234, 16'h0001, 16'h8000, -1, 0, -1, 0, -1, -1, lat);
    chk("lat_load1", lat, NR * (DW + 2) + 1);
    exp8 = 8'b0001_0010;
    if (bits_seen.size() >= 8) for (int i = 0; i < 8; i++) chk("bits_0x1234", bits_seen[i], exp8[7-i]);
    else chk("bits_count", bits_seen.size(), 8);
    if (rd_seen.size() == NR) chk("rd_first_lit", rd_seen[0], 16'hA5A5);
    else chk("rd_count1", rd_seen.size(), NR);
    repeat (2) @(posedge clk);
    #1;

    // Load 2: chain with the negedge output FF; must read back load 1.
    negff = 1'b1;
    run_load(16'h0000, 16'h0000, 16'h0000, -1, 0, -1, 0, -1, -1, lat);
    chk("lat_load2", lat, 55);
    lit = '{16'h1234, 16'h0001, 16'h8000};
    if (rd_seen.size() == NR) for (int i = 0; i < NR; i++) chk("rd_lit_load2", rd_seen[i], lit[i]);
    else chk("rd_count2", rd_seen.size(), NR);
    repeat (2) @(posedge clk);
    #1;

    // Load 3: scan shift low for 5 cycles mid-SHIFT delays done by 5.
    negff = 1'b0;
    run_load(16'hFFFF, 16'h0F0F, 16'h00FF, 5, 5, -1, 0, -1, -1, lat);
    chk("lat_scan_stall", lat, 60);
    repeat (2) @(posedge clk);
    #1;

    // Load 4: readback held off 10 cycles, plus a start pulse while busy.
    run_load(16'hBEEF, 16'h0000, 16'h0000, -1, 0, 18, 10, 30, -1, lat);
    chk("lat_rd_stall", lat, 65);
    if (rd_seen.size() == NR) chk("rd_first_load4", rd_seen[0], 16'hFFFF);
    else chk("rd_count4", rd_seen.size(), NR);
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_load4", {busy, wr_ready}, 0);
    end
    @(posedge clk); #1;

    // Load 5: reset at bit 7 of the second word abandons the load.
    run_load(16'h0001, 16'h0002, 16'h0003, -1, 0, -1, 0, -1, 7, lat);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("abort_no_done", {busy, done}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
